// File: rtl/iob_csrs_master.sv
// Single-outstanding IOb master: turns a command/response handshake into IOb CSR accesses.
// Optional response timeout is enabled by defining IOB_CSRS_MASTER_TIMEOUT_EN.
module iob_csrs_master #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input  logic                  clk_i,
  input  logic                  cke_i,
  input  logic                  arst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_W-1:0]     cmd_addr_i,
  input  logic [DATA_W-1:0]     cmd_wdata_i,
  input  logic [DATA_W/8-1:0]   cmd_wstrb_i,
  output logic                  iob_valid_o,
  output logic [ADDR_W-1:0]     iob_addr_o,
  output logic [DATA_W-1:0]     iob_wdata_o,
  output logic [DATA_W/8-1:0]   iob_wstrb_o,
  input  logic                  iob_ready_i,
  input  logic                  iob_rvalid_i,
  input  logic [DATA_W-1:0]     iob_rdata_i,
  output logic                  iob_rready_o,
  output logic                  resp_valid_o,
  output logic [DATA_W-1:0]     resp_rdata_o,
  output logic                  resp_err_o,
  input  logic                  resp_ready_i,
  output logic                  busy_o
);

  if ((TIMEOUT < 2) || (TIMEOUT > 65535)) begin : g_bad_timeout
    $error("iob_csrs_master: TIMEOUT must be within 2..65535");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t                state_q;
  logic                  cmd_rdy_q;
  logic                  busy_q;
  logic                  iob_valid_q;
  logic                  iob_rready_q;
  logic                  resp_valid_q;
  logic [ADDR_W-1:0]     iob_addr_q;
  logic [DATA_W-1:0]     iob_wdata_q;
  logic [DATA_W/8-1:0]   iob_wstrb_q;
  logic [DATA_W-1:0]     resp_rdata_q;

  logic                  cmd_hs_d;
  logic                  is_write_d;
  logic                  tmo_fire_d;

  assign cmd_hs_d   = cmd_valid_i & (state_q == IDLE);
  assign is_write_d = |iob_wstrb_q;

`ifdef IOB_CSRS_MASTER_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  logic [15:0] cnt_q;
  logic        resp_err_q;

  // A real completion in the same cycle always wins over the timeout.
  assign tmo_fire_d = (cnt_q == TMO_LAST) &&
                      (((state_q == REQ) && !iob_ready_i) ||
                       ((state_q == WAIT_R) && !iob_rvalid_i));

  // Wait-cycle counter: cleared on command acceptance, runs through REQ and WAIT_R
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      cnt_q <= 16'd0;
    end else if (cke_i) begin
      if (cmd_hs_d) begin
        cnt_q <= 16'd0;
      end else if ((state_q == REQ) || (state_q == WAIT_R)) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  // Error flag: set when a transaction is closed by timeout, cleared by the next command
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      resp_err_q <= 1'b0;
    end else if (cke_i) begin
      if (tmo_fire_d) begin
        resp_err_q <= 1'b1;
      end else if (cmd_hs_d) begin
        resp_err_q <= 1'b0;
      end
    end
  end

  assign resp_err_o = resp_err_q;
`else
  assign tmo_fire_d = 1'b0;
  assign resp_err_o = 1'b0;
`endif

  // Transaction FSM with all handshake outputs registered
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= IDLE;
      cmd_rdy_q    <= 1'b1;
      busy_q       <= 1'b0;
      iob_valid_q  <= 1'b0;
      iob_rready_q <= 1'b0;
      resp_valid_q <= 1'b0;
      iob_addr_q   <= '0;
      iob_wdata_q  <= '0;
      iob_wstrb_q  <= '0;
      resp_rdata_q <= '0;
    end else if (cke_i) begin
      case (state_q)
        IDLE: begin
          if (cmd_hs_d) begin
            state_q     <= REQ;
            cmd_rdy_q   <= 1'b0;
            busy_q      <= 1'b1;
            iob_valid_q <= 1'b1;
            iob_addr_q  <= cmd_addr_i;
            iob_wdata_q <= cmd_wdata_i;
            iob_wstrb_q <= cmd_wstrb_i;
          end
        end
        REQ: begin
          if (iob_ready_i) begin
            iob_valid_q <= 1'b0;
            if (is_write_d) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= '0;
            end else if (iob_rvalid_i) begin
              // Zero-latency read: data arrives with the request acceptance
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_rdata_q <= iob_rdata_i;
            end else begin
              state_q      <= WAIT_R;
              iob_rready_q <= 1'b1;
            end
          end else if (tmo_fire_d) begin
            state_q      <= RESP;
            iob_valid_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
          end
        end
        WAIT_R: begin
          if (iob_rvalid_i) begin
            state_q      <= RESP;
            iob_rready_q <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= iob_rdata_i;
          end else if (tmo_fire_d) begin
            state_q      <= RESP;
            iob_rready_q <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= '0;
          end
        end
        RESP: begin
          if (resp_ready_i) begin
            state_q      <= IDLE;
            cmd_rdy_q    <= 1'b1;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q      <= IDLE;
          cmd_rdy_q    <= 1'b1;
          busy_q       <= 1'b0;
          iob_valid_q  <= 1'b0;
          iob_rready_q <= 1'b0;
          resp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // The command port is closed for as long as reset is held
  assign cmd_ready_o  = cmd_rdy_q & ~arst_i;
  assign busy_o       = busy_q;
  assign iob_valid_o  = iob_valid_q;
  assign iob_addr_o   = iob_addr_q;
  assign iob_wdata_o  = iob_wdata_q;
  assign iob_wstrb_o  = iob_wstrb_q;
  assign iob_rready_o = iob_rready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_iob_csrs_master.sv
// Directed bench for iob_csrs_master: transaction-level reference model checked every cycle,
// plus literal expectations for the documented scenarios.
`timescale 1ns/1ps
module tb_iob_csrs_master;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
`ifdef IOB_CSRS_MASTER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              cke;
  logic              arst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [7:0]        cmd_addr;
  logic [31:0]       cmd_wdata;
  logic [3:0]        cmd_wstrb;
  logic              iob_valid;
  logic [7:0]        iob_addr;
  logic [31:0]       iob_wdata;
  logic [3:0]        iob_wstrb;
  logic              iob_ready;
  logic              iob_rvalid;
  logic [31:0]       iob_rdata;
  logic              iob_rready;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic              resp_ready;
  logic              busy;

  always #5 clk = ~clk;

  iob_csrs_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk), .cke_i(cke), .arst_i(arst),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_addr_i(cmd_addr),
    .cmd_wdata_i(cmd_wdata), .cmd_wstrb_i(cmd_wstrb),
    .iob_valid_o(iob_valid), .iob_addr_o(iob_addr), .iob_wdata_o(iob_wdata),
    .iob_wstrb_o(iob_wstrb), .iob_ready_i(iob_ready), .iob_rvalid_i(iob_rvalid),
    .iob_rdata_i(iob_rdata), .iob_rready_o(iob_rready),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .resp_ready_i(resp_ready), .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkw(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one open transaction, split into request / read-data / response phases
  logic        m_has = 1'b0, m_req = 1'b0, m_rd = 1'b0, m_resp = 1'b0, m_err = 1'b0;
  logic [7:0]  m_addr = 8'h00;
  logic [31:0] m_wdata = 32'h0, m_rdata = 32'h0;
  logic [3:0]  m_wstrb = 4'h0;
  int          m_wait = 0;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_has <= 1'b0; m_req <= 1'b0; m_rd <= 1'b0; m_resp <= 1'b0; m_err <= 1'b0;
      m_addr <= 8'h00; m_wdata <= 32'h0; m_wstrb <= 4'h0; m_rdata <= 32'h0; m_wait <= 0;
    end else if (cke) begin
      if (!m_has) begin
        if (cmd_valid) begin
          m_has <= 1'b1; m_req <= 1'b1; m_wait <= 0;
          m_addr <= cmd_addr; m_wdata <= cmd_wdata; m_wstrb <= cmd_wstrb;
        end
      end else if (m_req && iob_ready) begin
        m_req <= 1'b0;
        if (m_wstrb != 4'h0) begin
          m_resp <= 1'b1; m_rdata <= 32'h0; m_err <= 1'b0;
        end else if (iob_rvalid) begin
          m_resp <= 1'b1; m_rdata <= iob_rdata; m_err <= 1'b0;
        end else begin
          m_rd <= 1'b1;
        end
      end else if (m_rd && iob_rvalid) begin
        m_rd <= 1'b0; m_resp <= 1'b1; m_rdata <= iob_rdata; m_err <= 1'b0;
      end else if (m_req || m_rd) begin
        if (TMO_EN && (m_wait + 1 == TIMEOUT)) begin
          m_req <= 1'b0; m_rd <= 1'b0; m_resp <= 1'b1; m_rdata <= 32'h0; m_err <= 1'b1;
        end else begin
          m_wait <= m_wait + 1;
        end
      end else if (m_resp && resp_ready) begin
        m_resp <= 1'b0; m_has <= 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk1("cmd_ready", cmd_ready, !m_has && !arst);
    chk1("busy", busy, m_has);
    chk1("iob_valid", iob_valid, m_req);
    chk1("iob_rready", iob_rready, m_rd);
    chk1("resp_valid", resp_valid, m_resp);
    chkw("iob_addr", 32'(iob_addr), 32'(m_addr));
    chkw("iob_wdata", iob_wdata, m_wdata);
    chkw("iob_wstrb", 32'(iob_wstrb), 32'(m_wstrb));
    if (m_resp) begin
      chkw("resp_rdata", resp_rdata, m_rdata);
      chk1("resp_err", resp_err, m_err);
    end
  end

  int v_cnt = 0;
  int r_cnt = 0;
  always @(negedge clk) begin
    if (iob_valid === 1'b1) v_cnt <= v_cnt + 1;
    if (iob_rready === 1'b1) r_cnt <= r_cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input int budget);
    int n = 0;
    while (resp_valid !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    chk1("resp_within_budget", resp_valid, 1'b1);
  endtask

  task automatic finish_resp();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    int r0;
    cke = 1'b1; arst = 1'b1;
    cmd_valid = 1'b0; cmd_addr = 8'h00; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    iob_ready = 1'b0; iob_rvalid = 1'b0; iob_rdata = 32'h0; resp_ready = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chkw("rst_iob_addr", 32'(iob_addr), 32'h0);
    arst = 1'b0;
    #1;
    chk1("rel_cmd_ready", cmd_ready, 1'b1);
    tick();

    // Write with immediate iob_ready
    v0 = v_cnt;
    iob_ready = 1'b1;
    send_cmd(8'h04, 32'hA5A5_0001, 4'hF);
    tick();
    iob_ready = 1'b0;
    chkw("wr_valid_cycles", 32'(v_cnt - v0), 32'd1);
    chk1("wr_resp_valid", resp_valid, 1'b1);
    chkw("wr_resp_rdata", resp_rdata, 32'h0);
    chk1("wr_resp_err", resp_err, 1'b0);
    finish_resp();
    chk1("wr_idle_busy", busy, 1'b0);

    // Read: ready after 3 request cycles, data 2 cycles later
    v0 = v_cnt; r0 = r_cnt;
    send_cmd(8'h08, 32'h0, 4'h0);
    tick(); tick();
    iob_ready = 1'b1;
    tick();
    iob_ready = 1'b0;
    tick();
    iob_rvalid = 1'b1; iob_rdata = 32'h1234_5678;
    tick();
    iob_rvalid = 1'b0; iob_rdata = 32'h0;
    chkw("rd_valid_cycles", 32'(v_cnt - v0), 32'd3);
    chkw("rd_rready_cycles", 32'(r_cnt - r0), 32'd2);
    chk1("rd_resp_valid", resp_valid, 1'b1);
    chkw("rd_resp_rdata", resp_rdata, 32'h1234_5678);
    finish_resp();

    // Read with ready and rvalid together, response left pending
    r0 = r_cnt;
    send_cmd(8'h0C, 32'h0, 4'h0);
    iob_ready = 1'b1; iob_rvalid = 1'b1; iob_rdata = 32'hCAFE_F00D;
    tick();
    iob_ready = 1'b0; iob_rvalid = 1'b0; iob_rdata = 32'h0;
    chk1("fast_resp_valid", resp_valid, 1'b1);
    chkw("fast_resp_rdata", resp_rdata, 32'hCAFE_F00D);
    chkw("fast_rready_cycles", 32'(r_cnt - r0), 32'd0);

    // Back-pressure on the response while a new command waits
    cmd_valid = 1'b1; cmd_addr = 8'h10; cmd_wdata = 32'h0000_0005; cmd_wstrb = 4'h3;
    for (int i = 0; i < 5; i++) begin
      chk1("held_cmd_ready", cmd_ready, 1'b0);
      tick();
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk1("post_hs_cmd_ready", cmd_ready, 1'b1);
    chk1("post_hs_iob_valid", iob_valid, 1'b0);
    tick();
    cmd_valid = 1'b0;
    chk1("new_cmd_iob_valid", iob_valid, 1'b1);
    chkw("new_cmd_iob_addr", 32'(iob_addr), 32'h10);
    iob_ready = 1'b1;
    tick();
    iob_ready = 1'b0;
    finish_resp();

    // Clock enable low freezes a pending request and a pending response
    send_cmd(8'h20, 32'h0000_00AA, 4'h1);
    cke = 1'b0; iob_ready = 1'b1;
    tick(); tick(); tick();
    chk1("cke_iob_valid", iob_valid, 1'b1);
    chk1("cke_no_resp", resp_valid, 1'b0);
    cke = 1'b1;
    tick();
    iob_ready = 1'b0;
    chk1("cke_resp_valid", resp_valid, 1'b1);
    cke = 1'b0; resp_ready = 1'b1;
    tick(); tick();
    chk1("cke_resp_held", resp_valid, 1'b1);
    cke = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk1("cke_done_busy", busy, 1'b0);

    // Reset while waiting for read data, then a late rvalid
    send_cmd(8'h30, 32'h0, 4'h0);
    iob_ready = 1'b1;
    tick();
    iob_ready = 1'b0;
    chk1("waitr_rready", iob_rready, 1'b1);
    arst = 1'b1;
    #1;
    chk1("arst_busy", busy, 1'b0);
    chk1("arst_rready", iob_rready, 1'b0);
    chk1("arst_cmd_ready", cmd_ready, 1'b0);
    tick();
    arst = 1'b0;
    iob_rvalid = 1'b1; iob_rdata = 32'hDEAD_BEEF;
    tick(); tick();
    iob_rvalid = 1'b0; iob_rdata = 32'h0;
    chk1("late_rvalid_no_resp", resp_valid, 1'b0);
    chk1("late_rvalid_idle", cmd_ready, 1'b1);

    // Read that never gets iob_ready
    send_cmd(8'h40, 32'h0, 4'h0);
    v0 = v_cnt;
`ifdef IOB_CSRS_MASTER_TIMEOUT_EN
    wait_resp(40);
    chkw("tmo_valid_cycles", 32'(v_cnt - v0), 32'd16);
    chk1("tmo_resp_err", resp_err, 1'b1);
    chkw("tmo_resp_rdata", resp_rdata, 32'h0);
    chk1("tmo_iob_valid", iob_valid, 1'b0);
    finish_resp();
    chk1("tmo_idle", busy, 1'b0);
`else
    repeat (40) tick();
    chk1("notmo_busy", busy, 1'b1);
    chk1("notmo_iob_valid", iob_valid, 1'b1);
    chkw("notmo_valid_cycles", 32'(v_cnt - v0), 32'd40);
    chk1("notmo_no_resp", resp_valid, 1'b0);
    arst = 1'b1;
    tick();
    arst = 1'b0;
    tick();
    chk1("notmo_recovered", busy, 1'b0);
`endif

    // One more write to confirm normal service after the above
    send_cmd(8'h44, 32'h0BAD_CAFE, 4'h8);
    iob_ready = 1'b1;
    tick();
    iob_ready = 1'b0;
    wait_resp(4);
    chkw("final_wr_rdata", resp_rdata, 32'h0);
    finish_resp();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/iob_csrs_master.md
IOB_CSRS_MASTER -- requirements
Module: iob_csrs_master

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, IOb address width in bits.
REQ-002 The block SHALL have parameter DATA_W, default 32, IOb data width in bits.
REQ-003 The block SHALL have parameter TIMEOUT, default 256, response timeout in clock cycles (range 2..65535).
REQ-004 clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 cke_i  in  1  clock enable; when 0, all registers hold.
REQ-006 arst_i  in  1  asynchronous, active-high reset.
REQ-007 cmd_valid_i  in  1  command present.
REQ-008 cmd_ready_o  out  1  command accepted when high with cmd_valid_i.
REQ-009 cmd_addr_i  in  ADDR_W  target CSR address.
REQ-010 cmd_wdata_i  in  DATA_W  write data.
REQ-011 cmd_wstrb_i  in  DATA_W/8  byte strobes; nonzero = write, zero = read.
REQ-012 iob_valid_o, iob_addr_o, iob_wdata_o, iob_wstrb_o  out  1/ADDR_W/DATA_W/DATA_W/8  IOb request to the CSR block.
REQ-013 iob_ready_i  in  1  request accepted by the CSR block.
REQ-014 iob_rvalid_i, iob_rdata_i  in  1/DATA_W  read response.
REQ-015 iob_rready_o  out  1  read response accepted.
REQ-016 resp_valid_o, resp_rdata_o, resp_err_o  out  1/DATA_W/1  completion to the command source.
REQ-017 resp_ready_i  in  1  completion consumed.
REQ-018 busy_o  out  1  high in any state other than IDLE.

Function
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT_R and RESP.
REQ-020 cmd_ready_o SHALL be high only in IDLE; a handshake in cycle N SHALL register addr/wdata/wstrb, enter REQ and assert iob_valid_o in cycle N+1.
REQ-021 In REQ, iob_valid_o and the request fields SHALL remain stable until the cycle in which iob_ready_i is high.
REQ-022 For a write, the iob_ready_i cycle SHALL move to RESP with resp_rdata_o=0 and resp_err_o=0; no rvalid is expected.
REQ-023 For a read, the iob_ready_i cycle SHALL deassert iob_valid_o in the next cycle and enter WAIT_R, with iob_rready_o high throughout WAIT_R.
REQ-024 In WAIT_R, iob_rvalid_i high SHALL capture iob_rdata_i into resp_rdata_o and enter RESP; iob_rvalid_i in any other state SHALL be ignored.
REQ-025 In RESP, resp_valid_o SHALL be high with stable data until resp_ready_i; that cycle SHALL return the FSM to IDLE.
REQ-026 Exactly one transaction SHALL be outstanding; a new command SHALL be accepted no earlier than the cycle after the RESP handshake.
REQ-027 iob_ready_i and iob_rvalid_i both high in the same REQ cycle of a read SHALL capture the data and go directly to RESP.
REQ-028 When cke_i=0, the state, counters and outputs SHALL hold, and no handshake SHALL complete.

Reset
REQ-029 arst_i SHALL immediately force IDLE and the following values: cmd_ready_o=0 while arst_i is high, then 1; iob_valid_o=0; iob_addr_o, iob_wdata_o, iob_wstrb_o=0; iob_rready_o=0; resp_valid_o=0; resp_rdata_o=0; resp_err_o=0; busy_o=0.
REQ-030 Reset asserted mid-transaction SHALL abandon it without any response; a late iob_rvalid_i after reset SHALL be ignored.

Configuration
REQ-031 With IOB_CSRS_MASTER_TIMEOUT_EN defined, a cycle counter SHALL run in REQ and WAIT_R and clear on entering REQ. Reaching TIMEOUT cycles SHALL drop iob_valid_o and iob_rready_o and enter RESP with resp_err_o=1 and resp_rdata_o=0.
REQ-032 Without IOB_CSRS_MASTER_TIMEOUT_EN, the counter SHALL be absent, REQ and WAIT_R SHALL wait indefinitely, and resp_err_o SHALL be constant 0.

Verification
REQ-033 Write addr 0x04, wdata 0xA5A5_0001, wstrb 0xF, iob_ready_i high at the first request cycle -> one iob_valid_o cycle; resp_valid_o with rdata 0 and err 0.
REQ-034 Read addr 0x08, ready after 3 cycles, rvalid 2 cycles later with 0x1234_5678 -> resp_rdata_o=0x1234_5678; iob_rready_o high only in WAIT_R.
REQ-035 Read with iob_ready_i and iob_rvalid_i high in the same cycle (data 0xCAFE_F00D) -> direct REQ->RESP; data correct.
REQ-036 resp_ready_i held low for 5 cycles with a new cmd_valid_i pending -> cmd_ready_o stays 0; the command is accepted the cycle after the RESP handshake.
REQ-037 arst_i pulsed while in WAIT_R, then iob_rvalid_i applied -> no resp_valid_o; the block is in IDLE.
REQ-038 With IOB_CSRS_MASTER_TIMEOUT_EN and TIMEOUT=16, a read that gets no iob_ready_i -> resp_err_o=1 and rdata 0 after 16 REQ cycles; without the macro, busy_o stays high.
